// File: rtl/sram_bank_array.sv
// NUM_BANKS sky130 32x512 SRAM macros tiled into one deeper 32-bit memory with
// a read/write port A, a read-only port B and an optional zero-fill after reset.

`ifndef SKY130_SRAM_HARD_MACRO
// Behavioural stand-in for the hard macro: inputs captured on the rising edge,
// dout valid for the following cycle and held until the next read on that port.
module sky130_sram_2kbyte_1rw1r_32x512_8 (
`ifdef USE_POWER_PINS
   inout  wire          vccd1,
   inout  wire          vssd1,
`endif
   input  logic         clk0,
   input  logic         csb0,
   input  logic         web0,
   input  logic [3:0]   wmask0,
   input  logic [8:0]   addr0,
   input  logic [31:0]  din0,
   output logic [31:0]  dout0,
   input  logic         clk1,
   input  logic         csb1,
   input  logic [8:0]   addr1,
   output logic [31:0]  dout1
);
   logic [31:0] mem [512];

   always_ff @(posedge clk0) begin
      if (!csb0 && !web0) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
         end
      end
      if (!csb0 && web0) dout0 <= mem[addr0];
   end

   always_ff @(posedge clk1) begin
      if (!csb1) dout1 <= mem[addr1];
   end
endmodule
`endif

// Handshake: a request on a port is taken at a rising edge where valid & ready;
// a taken read returns rvalid (one-cycle pulse) with rdata on the next cycle.
module sram_bank_array #(
   parameter  int NUM_BANKS = 2,
   parameter  int INIT_ZERO = 1,
   localparam int AW        = 9 + $clog2(NUM_BANKS)
) (
`ifdef USE_POWER_PINS
   inout  wire            vccd1,
   inout  wire            vssd1,
`endif
   input  logic           clk0,
   input  logic           rst0,
   input  logic           a_valid,
   output logic           a_ready,
   input  logic           a_we,
   input  logic [3:0]     a_wmask,
   input  logic [AW-1:0]  a_addr,
   input  logic [31:0]    a_wdata,
   output logic           a_rvalid,
   output logic [31:0]    a_rdata,
   input  logic           b_valid,
   output logic           b_ready,
   input  logic [AW-1:0]  b_addr,
   output logic           b_rvalid,
   output logic [31:0]    b_rdata,
   output logic           init_done,
   output logic [0:0]     dbg_state
);
   localparam int BSW = $clog2(NUM_BANKS);
   localparam int BW  = (BSW > 0) ? BSW : 1;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [8:0]    cnt_q, cnt_d;
   logic          a_rvalid_q, a_rvalid_d;
   logic          b_rvalid_q, b_rvalid_d;
   logic [BW-1:0] a_sel_q, a_sel_d;
   logic [BW-1:0] b_sel_q, b_sel_d;
   logic [31:0]   a_hold_q, a_hold_d;
   logic [31:0]   b_hold_q, b_hold_d;

   logic [BW-1:0] a_bank, b_bank;
   logic [8:0]    a_row, b_row;
   logic          run, a_fire, b_fire, init_wr;

   logic [NUM_BANKS-1:0] csb0, csb1;
   logic                 web0;
   logic [3:0]           wmask0;
   logic [8:0]           addr0;
   logic [31:0]          din0;
   logic [31:0]          dout0 [NUM_BANKS];
   logic [31:0]          dout1 [NUM_BANKS];

   if (NUM_BANKS > 1) begin : g_split
      assign a_bank = a_addr[AW-1:9];
      assign b_bank = b_addr[AW-1:9];
   end else begin : g_single
      assign a_bank = '0;
      assign b_bank = '0;
   end

   assign a_row = a_addr[8:0];
   assign b_row = b_addr[8:0];

   assign run       = (state_q == ST_RUN);
   assign init_done = run;
   assign dbg_state = state_q;
   assign a_ready   = run;
   // A write to the address B wants to read wins; B simply retries.
   assign b_ready   = run && !(a_valid && a_we && (a_addr == b_addr));
   assign a_fire    = a_valid && a_ready;
   assign b_fire    = b_valid && b_ready;
   assign init_wr   = (state_q == ST_INIT) && (INIT_ZERO != 0);

   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_rdata  = a_rvalid_q ? dout0[a_sel_q] : a_hold_q;
   assign b_rdata  = b_rvalid_q ? dout1[b_sel_q] : b_hold_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         if ((INIT_ZERO == 0) || (cnt_q == 9'd511)) state_d = ST_RUN;
         else                                      cnt_d   = cnt_q + 9'd1;
      end

      a_rvalid_d = a_fire && !a_we;
      b_rvalid_d = b_fire;
      a_sel_d    = a_fire ? a_bank : a_sel_q;
      b_sel_d    = b_fire ? b_bank : b_sel_q;
      a_hold_d   = a_rdata;
      b_hold_d   = b_rdata;
   end

   // Zero-fill writes every bank at the same row, so only csb0 differs per bank.
   always_comb begin
      web0   = init_wr ? 1'b0  : !a_we;
      wmask0 = init_wr ? 4'hF  : a_wmask;
      addr0  = init_wr ? cnt_q : a_row;
      din0   = init_wr ? 32'h0 : a_wdata;
      csb0   = '1;
      csb1   = '1;
      for (int i = 0; i < NUM_BANKS; i++) begin
         csb0[i] = !(init_wr || (a_fire && (a_bank == BW'(i))));
         csb1[i] = !(b_fire && (b_bank == BW'(i)));
      end
   end

   always_ff @(posedge clk0) begin
      if (rst0) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_sel_q    <= '0;
         b_sel_q    <= '0;
         a_hold_q   <= '0;
         b_hold_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         a_sel_q    <= a_sel_d;
         b_sel_q    <= b_sel_d;
         a_hold_q   <= a_hold_d;
         b_hold_q   <= b_hold_d;
      end
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
`ifdef USE_POWER_PINS
         .vccd1  (vccd1),
         .vssd1  (vssd1),
`endif
         .clk0   (clk0),
         .csb0   (csb0[g]),
         .web0   (web0),
         .wmask0 (wmask0),
         .addr0  (addr0),
         .din0   (din0),
         .dout0  (dout0[g]),
         .clk1   (clk0),
         .csb1   (csb1[g]),
         .addr1  (b_row),
         .dout1  (dout1[g])
      );
   end
endmodule

// File: tb/tb_sram_bank_array.sv
// Bench for sram_bank_array (2 banks, zero-fill) plus a no-fill instance for init timing.
module tb_sram_bank_array;
   localparam int AW = 10;

   logic          clk0 = 1'b0;
   logic          rst0;
   logic          a_valid, a_we, b_valid;
   logic [3:0]    a_wmask;
   logic [AW-1:0] a_addr, b_addr;
   logic [31:0]   a_wdata;
   logic          a_ready, b_ready, a_rvalid, b_rvalid, init_done;
   logic [31:0]   a_rdata, b_rdata;
   logic [0:0]    dbg_state;

   logic          nz_a_ready, nz_b_ready, nz_a_rvalid, nz_b_rvalid, nz_init_done;
   logic [31:0]   nz_a_rdata, nz_b_rdata;
   logic [0:0]    nz_dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: word array plus one expected-read queue per port
   logic [31:0] mem_m [1024];
   logic        run_m;
   logic        a_pend, b_pend;
   logic [31:0] a_exp_q[$];
   logic [31:0] b_exp_q[$];

   always #5 clk0 = ~clk0;

   sram_bank_array #(.NUM_BANKS(2), .INIT_ZERO(1)) u_dut (
      .clk0(clk0), .rst0(rst0),
      .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask),
      .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr),
      .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .init_done(init_done), .dbg_state(dbg_state)
   );

   sram_bank_array #(.NUM_BANKS(2), .INIT_ZERO(0)) u_dut_nz (
      .clk0(clk0), .rst0(rst0),
      .a_valid(1'b0), .a_ready(nz_a_ready), .a_we(1'b0), .a_wmask(4'h0),
      .a_addr('0), .a_wdata(32'h0), .a_rvalid(nz_a_rvalid), .a_rdata(nz_a_rdata),
      .b_valid(1'b0), .b_ready(nz_b_ready), .b_addr('0),
      .b_rvalid(nz_b_rvalid), .b_rdata(nz_b_rdata),
      .init_done(nz_init_done), .dbg_state(nz_dbg_state)
   );

   task automatic tick();
      @(posedge clk0);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic we, input logic [3:0] m,
                          input logic [AW-1:0] ad, input logic [31:0] d);
      a_valid = v; a_we = we; a_wmask = m; a_addr = ad; a_wdata = d;
   endtask

   task automatic drive_b(input logic v, input logic [AW-1:0] ad);
      b_valid = v; b_addr = ad;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;
   endtask

   // one clock: decide acceptance from the rules, queue read data, apply writes
   task automatic cycle();
      logic a_acc, b_acc;
      logic [AW-1:0] wa;
      logic [31:0] wd;
      logic [3:0] wm;
      a_exp_q.delete();
      b_exp_q.delete();
      a_acc = run_m && a_valid;
      b_acc = run_m && b_valid && !(a_valid && a_we && (a_addr == b_addr));
      if (a_acc && !a_we) a_exp_q.push_back(mem_m[a_addr]);
      if (b_acc) b_exp_q.push_back(mem_m[b_addr]);
      a_pend = a_acc && !a_we;
      b_pend = b_acc;
      wa = a_addr; wd = a_wdata; wm = a_wmask;
      tick();
      if (a_acc && a_we) begin
         for (int i = 0; i < 4; i++)
            if (wm[i]) mem_m[wa][8*i +: 8] = wd[8*i +: 8];
      end
   endtask

   function automatic logic [AW-1:0] pick_addr();
      logic [8:0] rows [6];
      rows[0] = 9'd0; rows[1] = 9'd1; rows[2] = 9'd2;
      rows[3] = 9'd509; rows[4] = 9'd510; rows[5] = 9'd511;
      return {1'($urandom_range(0, 1)), rows[$urandom_range(0, 5)]};
   endfunction

   task automatic test_reset();
      int cycles;
      run_m = 1'b0;
      rst0 = 1'b1;
      drive_a(0, 0, 4'h0, '0, 32'h0);
      drive_b(1, '0);
      repeat (3) tick();
      n_checks++;
      if ({a_rvalid, b_rvalid, init_done, a_ready, b_ready} !== 5'b0 ||
          a_rdata !== 32'h0 || b_rdata !== 32'h0)
         $display("FAIL reset_outputs: got rv=%b%b done=%b rdy=%b%b rdata=%h/%h, need all zero",
                  a_rvalid, b_rvalid, init_done, a_ready, b_ready, a_rdata, b_rdata);
      else n_pass++;
      drive_b(0, '0);
      rst0 = 1'b0;
      cycles = 0;
      for (int i = 1; i <= 600; i++) begin
         tick();
         if (i == 1) begin
            n_checks++;
            if (nz_init_done !== 1'b1)
               $display("FAIL nofill_init_done: got %b one cycle after reset, need 1", nz_init_done);
            else n_pass++;
         end
         if (init_done === 1'b1) begin cycles = i; break; end
      end
      n_checks++;
      if (cycles != 512) $display("FAIL init_cycles: got %0d, need 512", cycles);
      else n_pass++;
      run_m = 1'b1;
      clear_model();
      for (int k = 0; k < 4; k++) begin
         logic [AW-1:0] ads [4];
         ads[0] = 10'd0; ads[1] = 10'd511; ads[2] = 10'd512; ads[3] = 10'd1023;
         drive_a(1, 0, 4'h0, ads[k], 32'h0);
         cycle();
         drive_a(0, 0, 4'h0, '0, 32'h0);
         n_checks++;
         if (a_rvalid !== 1'b1 || a_rdata !== 32'h0)
            $display("FAIL init_zero_read: addr %h got rv=%b data=%h, need rv=1 data=0",
                     ads[k], a_rvalid, a_rdata);
         else n_pass++;
      end
      cycle();
   endtask

   task automatic test_bank_rw();
      drive_a(1, 1, 4'hF, 10'h005, 32'hDEADBEEF);
      cycle();
      drive_a(1, 1, 4'hF, 10'h205, 32'h12345678);
      cycle();
      n_checks++;
      if (a_rvalid !== 1'b0) $display("FAIL write_no_resp: got a_rvalid=%b, need 0", a_rvalid);
      else n_pass++;
      drive_a(1, 0, 4'h0, 10'h205, 32'h0);
      cycle();
      drive_a(1, 0, 4'h0, 10'h005, 32'h0);
      n_checks++;
      if (a_rvalid !== 1'b1 || a_rdata !== 32'h12345678)
         $display("FAIL b2b_read0: got rv=%b data=%h, need rv=1 data=12345678", a_rvalid, a_rdata);
      else n_pass++;
      cycle();
      drive_a(0, 0, 4'h0, '0, 32'h0);
      n_checks++;
      if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF)
         $display("FAIL b2b_read1: got rv=%b data=%h, need rv=1 data=deadbeef", a_rvalid, a_rdata);
      else n_pass++;
      cycle();
      n_checks++;
      if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF)
         $display("FAIL rdata_hold_a: got rv=%b data=%h, need rv=0 data=deadbeef", a_rvalid, a_rdata);
      else n_pass++;
   endtask

   task automatic test_wmask();
      drive_a(1, 1, 4'hF, 10'h010, 32'h11223344);
      cycle();
      drive_a(1, 1, 4'b0101, 10'h010, 32'hAABBCCDD);
      cycle();
      drive_a(1, 0, 4'h0, 10'h010, 32'h0);
      cycle();
      drive_a(0, 0, 4'h0, '0, 32'h0);
      n_checks++;
      if (a_rvalid !== 1'b1 || a_rdata !== 32'h11BB33DD)
         $display("FAIL byte_mask: got rv=%b data=%h, need rv=1 data=11bb33dd", a_rvalid, a_rdata);
      else n_pass++;
   endtask

   task automatic test_collision();
      drive_a(1, 1, 4'hF, 10'h0F0, 32'hCAFEF00D);
      drive_b(1, 10'h0F0);
      #1;
      n_checks++;
      if (b_ready !== 1'b0 || a_ready !== 1'b1)
         $display("FAIL collision_ready: got a_ready=%b b_ready=%b, need 1/0", a_ready, b_ready);
      else n_pass++;
      cycle();
      drive_a(0, 0, 4'h0, '0, 32'h0);
      #1;
      n_checks++;
      if (b_ready !== 1'b1 || b_rvalid !== 1'b0)
         $display("FAIL collision_retry: got b_ready=%b b_rvalid=%b, need 1/0", b_ready, b_rvalid);
      else n_pass++;
      cycle();
      drive_b(0, '0);
      n_checks++;
      if (b_rvalid !== 1'b1 || b_rdata !== 32'hCAFEF00D)
         $display("FAIL collision_data: got rv=%b data=%h, need rv=1 data=cafef00d", b_rvalid, b_rdata);
      else n_pass++;
   endtask

   task automatic test_dual_read();
      drive_a(1, 1, 4'hF, 10'h3FF, 32'h0BADC0DE);
      cycle();
      drive_a(1, 0, 4'h0, 10'h3FF, 32'h0);
      drive_b(1, 10'h3FF);
      cycle();
      drive_a(0, 0, 4'h0, '0, 32'h0);
      drive_b(0, '0);
      n_checks++;
      if (a_rvalid !== 1'b1 || b_rvalid !== 1'b1 ||
          a_rdata !== 32'h0BADC0DE || b_rdata !== 32'h0BADC0DE)
         $display("FAIL dual_read: got rv=%b%b data=%h/%h, need rv=11 data=0badc0de",
                  a_rvalid, b_rvalid, a_rdata, b_rdata);
      else n_pass++;
      repeat (3) cycle();
      n_checks++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 ||
          a_rdata !== 32'h0BADC0DE || b_rdata !== 32'h0BADC0DE)
         $display("FAIL dual_hold: got rv=%b%b data=%h/%h, need rv=00 data=0badc0de",
                  a_rvalid, b_rvalid, a_rdata, b_rdata);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] a_last, b_last, exp;
      logic exp_br;
      a_last = a_rdata;
      b_last = b_rdata;
      for (int it = 0; it < 400; it++) begin
         drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), pick_addr(), $urandom);
         drive_b(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? a_addr : pick_addr());
         #1;
         exp_br = !(a_valid && a_we && (a_addr == b_addr));
         n_checks++;
         if (b_ready !== exp_br || a_ready !== 1'b1)
            $display("FAIL rand_ready: it %0d got a/b_ready=%b%b, need 1%b", it, a_ready, b_ready, exp_br);
         else n_pass++;
         cycle();
         n_checks++;
         if (a_rvalid !== a_pend)
            $display("FAIL rand_a_rvalid: it %0d got %b, need %b", it, a_rvalid, a_pend);
         else n_pass++;
         if (a_pend) a_last = a_exp_q.pop_front();
         n_checks++;
         if (a_rdata !== a_last)
            $display("FAIL rand_a_rdata: it %0d got %h, need %h", it, a_rdata, a_last);
         else n_pass++;
         n_checks++;
         if (b_rvalid !== b_pend)
            $display("FAIL rand_b_rvalid: it %0d got %b, need %b", it, b_rvalid, b_pend);
         else n_pass++;
         if (b_pend) b_last = b_exp_q.pop_front();
         n_checks++;
         if (b_rdata !== b_last)
            $display("FAIL rand_b_rdata: it %0d got %h, need %h", it, b_rdata, b_last);
         else n_pass++;
      end
      drive_a(0, 0, 4'h0, '0, 32'h0);
      drive_b(0, '0);
      exp = 32'h0;
      cycle();
   endtask

   task automatic test_reset_mid_init();
      int cycles;
      run_m = 1'b0;
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      repeat (300) tick();
      n_checks++;
      if (init_done !== 1'b0) $display("FAIL mid_init_done: got %b at cnt 300, need 0", init_done);
      else n_pass++;
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      cycles = 0;
      for (int i = 1; i <= 600; i++) begin
         tick();
         if (i == 1) begin
            n_checks++;
            if (nz_init_done !== 1'b1)
               $display("FAIL nofill_reinit: got %b one cycle after reset, need 1", nz_init_done);
            else n_pass++;
         end
         if (init_done === 1'b1) begin cycles = i; break; end
      end
      n_checks++;
      if (cycles != 512) $display("FAIL reinit_cycles: got %0d, need 512", cycles);
      else n_pass++;
      run_m = 1'b1;
      clear_model();
      drive_a(1, 0, 4'h0, 10'h005, 32'h0);
      drive_b(1, 10'h205);
      cycle();
      drive_a(0, 0, 4'h0, '0, 32'h0);
      drive_b(0, '0);
      n_checks++;
      if (a_rvalid !== 1'b1 || b_rvalid !== 1'b1 || a_rdata !== 32'h0 || b_rdata !== 32'h0)
         $display("FAIL refill_zero: got rv=%b%b data=%h/%h, need rv=11 data=0",
                  a_rvalid, b_rvalid, a_rdata, b_rdata);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_bank_rw();
      test_wmask();
      test_collision();
      test_dual_read();
      test_random();
      test_reset_mid_init();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
